// File: rtl/cva6_icache_data_pkg.sv
// Shared types for the instruction-cache data-array controller.
//   state_e : controller FSM states (idle, read response pending, response held)
//   ways_t  : one-hot way vector for the default four-way configuration
package cva6_icache_data_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam int unsigned DefaultWayCount = 4;

    typedef logic [DefaultWayCount-1:0] ways_t;

endpackage

// File: rtl/cva6_icache_data_if.sv
// Bus bundle between the cache front end, the refill engine and the data SRAMs.
//   read request : rd_valid_i, rd_ready_o, rd_addr_i
//   read response: rd_way_i, rsp_valid_o, rsp_ready_i, rsp_data_o, rsp_hit_o, rsp_err_o
//   refill       : fill_valid_i, fill_ready_o, fill_addr_i, fill_way_i, fill_data_i
//   kill         : flush_i
//   SRAM         : sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, sram_rdata_i
// Suffixes are from the controller's point of view; modport slave is the
// controller, modport master is everything around it.
interface cva6_icache_data_if #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned WayCount  = 4
);
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned BeWidth   = (DataWidth + 7) / 8;

    logic                                 rd_valid_i;
    logic                                 rd_ready_o;
    logic [AddrWidth-1:0]                 rd_addr_i;

    logic [WayCount-1:0]                  rd_way_i;
    logic                                 rsp_valid_o;
    logic                                 rsp_ready_i;
    logic [DataWidth-1:0]                 rsp_data_o;
    logic                                 rsp_hit_o;
    logic                                 rsp_err_o;

    logic                                 fill_valid_i;
    logic                                 fill_ready_o;
    logic [AddrWidth-1:0]                 fill_addr_i;
    logic [WayCount-1:0]                  fill_way_i;
    logic [DataWidth-1:0]                 fill_data_i;

    logic                                 flush_i;

    logic [WayCount-1:0]                  sram_req_o;
    logic                                 sram_we_o;
    logic [AddrWidth-1:0]                 sram_addr_o;
    logic [DataWidth-1:0]                 sram_wdata_o;
    logic [BeWidth-1:0]                   sram_be_o;
    logic [WayCount-1:0][DataWidth-1:0]   sram_rdata_i;

    modport slave (
        input  rd_valid_i, rd_addr_i,
        output rd_ready_o,
        input  rd_way_i, rsp_ready_i,
        output rsp_valid_o, rsp_data_o, rsp_hit_o, rsp_err_o,
        input  fill_valid_i, fill_addr_i, fill_way_i, fill_data_i,
        output fill_ready_o,
        input  flush_i,
        output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
        input  sram_rdata_i
    );

    modport master (
        output rd_valid_i, rd_addr_i,
        input  rd_ready_o,
        output rd_way_i, rsp_ready_i,
        input  rsp_valid_o, rsp_data_o, rsp_hit_o, rsp_err_o,
        output fill_valid_i, fill_addr_i, fill_way_i, fill_data_i,
        input  fill_ready_o,
        output flush_i,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
        output sram_rdata_i
    );

endinterface

// File: rtl/cva6_icache_way_sel.sv
// Combinational way multiplexer with hit and multi-hit detection.
//   rdata : per-way SRAM read rows
//   way   : tag-compare result, expected one-hot
//   data  : OR of rows whose way bit is set (zero when nothing hits)
//   hit   : at least one way bit set
//   err   : more than one way bit set
module cva6_icache_way_sel #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned WayCount  = 4
) (
    input  logic [WayCount-1:0][DataWidth-1:0] rdata,
    input  logic [WayCount-1:0]                way,
    output logic [DataWidth-1:0]               data,
    output logic                               hit,
    output logic                               err
);

    always_comb begin
        data = '0;
        hit  = 1'b0;
        err  = 1'b0;
        for (int unsigned w = 0; w < WayCount; w++) begin
            if (way[w]) begin
                data = data | rdata[w];
                // A second set bit after one has already been seen is a multi-hit.
                if (hit) begin
                    err = 1'b1;
                end
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cva6_icache_data_ctrl.sv
// Instruction-cache data-array controller.
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus (slave)  : read request/response, refill write, flush and SRAM ports
// Refills always win the SRAM; reads are accepted only when no refill or
// flush is present and the response path can advance. The response comes
// straight from the SRAM one cycle after accept, or from hold registers
// when the consumer stalls.
module cva6_icache_data_ctrl
    import cva6_icache_data_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned WayCount  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cva6_icache_data_if.slave    bus
);

    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned BeWidth   = (DataWidth + 7) / 8;

    state_e                 state;
    state_e                 state_next;

    logic                   rd_ready;
    logic                   rd_fire;
    logic                   capture;

    logic [DataWidth-1:0]   sel_data;
    logic                   sel_hit;
    logic                   sel_err;

    logic [DataWidth-1:0]   hold_data;
    logic                   hold_hit;
    logic                   hold_err;

    cva6_icache_way_sel #(
        .DataWidth (DataWidth),
        .WayCount  (WayCount)
    ) u_way_sel (
        .rdata (bus.sram_rdata_i),
        .way   (bus.rd_way_i),
        .data  (sel_data),
        .hit   (sel_hit),
        .err   (sel_err)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_hit  <= 1'b0;
            hold_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                hold_data <= sel_data;
                hold_hit  <= sel_hit;
                hold_err  <= sel_err;
            end
        end
    end

    always_comb begin
        rd_ready = !bus.fill_valid_i && !bus.flush_i &&
                   ((state == IDLE) || ((state == RD_WAIT) && bus.rsp_ready_i));
        rd_fire  = bus.rd_valid_i && rd_ready;

        bus.rd_ready_o   = rd_ready;
        bus.fill_ready_o = 1'b1;

        bus.sram_req_o   = '0;
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        bus.sram_be_o    = '0;

        if (bus.fill_valid_i) begin
            bus.sram_req_o   = bus.fill_way_i;
            bus.sram_we_o    = 1'b1;
            bus.sram_addr_o  = bus.fill_addr_i;
            bus.sram_wdata_o = bus.fill_data_i;
            bus.sram_be_o    = '1;
        end else if (rd_fire) begin
            bus.sram_req_o  = '1;
            bus.sram_addr_o = bus.rd_addr_i;
        end

        state_next      = state;
        capture         = 1'b0;
        bus.rsp_valid_o = 1'b0;
        bus.rsp_data_o  = '0;
        bus.rsp_hit_o   = 1'b0;
        bus.rsp_err_o   = 1'b0;

        case (state)
            IDLE: begin
                if (rd_fire) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Reset in this cycle drops the pending response outright.
                bus.rsp_valid_o = !bus.flush_i && !rst_i;
                bus.rsp_data_o  = sel_data;
                bus.rsp_hit_o   = sel_hit;
                bus.rsp_err_o   = sel_err;
                if (bus.flush_i) begin
                    state_next = IDLE;
                end else if (!bus.rsp_ready_i) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else if (rd_fire) begin
                    state_next = RD_WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                bus.rsp_valid_o = !bus.flush_i && !rst_i;
                bus.rsp_data_o  = hold_data;
                bus.rsp_hit_o   = hold_hit;
                bus.rsp_err_o   = hold_err;
                if (bus.flush_i || bus.rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cva6_icache_data_ctrl.sv
// Directed bench for cva6_icache_data_ctrl with a behavioural read-first SRAM.
module tb_cva6_icache_data_ctrl;
    import cva6_icache_data_pkg::*;

    localparam int unsigned NW = 1024;
    localparam int unsigned DW = 128;
    localparam int unsigned WC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cva6_icache_data_if #(.NumWords(NW), .DataWidth(DW), .WayCount(WC)) bus ();

    cva6_icache_data_ctrl #(.NumWords(NW), .DataWidth(DW), .WayCount(WC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:WC-1][0:NW-1];

    always @(posedge clk) begin
        for (int w = 0; w < int'(WC); w++) begin
            if (bus.sram_req_o[w]) begin
                if (bus.sram_we_o) mem[w][bus.sram_addr_o] <= bus.sram_wdata_o;
                else               bus.sram_rdata_i[w]     <= mem[w][bus.sram_addr_o];
            end
        end
    end

    localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] D_5A = {16{8'h5A}};
    localparam logic [DW-1:0] D_11 = {16{8'h11}};
    localparam logic [DW-1:0] D_22 = {16{8'h22}};
    localparam logic [DW-1:0] D_33 = {16{8'h33}};
    localparam logic [DW-1:0] D_C3 = {16{8'hC3}};

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [9:0] addr, input ways_t way, input logic [DW-1:0] data);
        tick();
        bus.fill_valid_i = 1'b1;
        bus.fill_addr_i  = addr;
        bus.fill_way_i   = way;
        bus.fill_data_i  = data;
        #2;
        chk("fill_req", DW'(bus.sram_req_o), DW'(way));
        chk("fill_we", DW'(bus.sram_we_o), DW'(1));
        tick();
        bus.fill_valid_i = 1'b0;
    endtask

    initial begin
        bus.rd_valid_i   = 1'b0;
        bus.rd_addr_i    = '0;
        bus.rd_way_i     = '0;
        bus.rsp_ready_i  = 1'b1;
        bus.fill_valid_i = 1'b0;
        bus.fill_addr_i  = '0;
        bus.fill_way_i   = '0;
        bus.fill_data_i  = '0;
        bus.flush_i      = 1'b0;
        bus.sram_rdata_i = '0;

        // Reset
        tick();
        tick();
        chk("rst_rsp_valid", DW'(bus.rsp_valid_o), DW'(0));
        chk("rst_sram_req", DW'(bus.sram_req_o), DW'(0));
        rst = 1'b0;
        #2;
        chk("post_rst_rd_ready", DW'(bus.rd_ready_o), DW'(1));
        chk("post_rst_fill_ready", DW'(bus.fill_ready_o), DW'(1));
        chk("post_rst_rsp_valid", DW'(bus.rsp_valid_o), DW'(0));

        // Preload rows
        fill(10'h010, 4'b0001, D_11);
        fill(10'h010, 4'b0010, D_22);
        fill(10'h010, 4'b0100, D_A5);
        fill(10'h010, 4'b1000, D_33);
        for (int k = 0; k < 4; k++) fill(10'h020 + 10'(k), 4'b0010, {16{8'h40 + 8'(k)}});

        // Single read, way2 hit
        tick();
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = 10'h010;
        #2;
        chk("rd1_ready", DW'(bus.rd_ready_o), DW'(1));
        chk("rd1_req", DW'(bus.sram_req_o), DW'(4'b1111));
        chk("rd1_we", DW'(bus.sram_we_o), DW'(0));
        chk("rd1_addr", DW'(bus.sram_addr_o), DW'(10'h010));
        tick();
        bus.rd_valid_i = 1'b0;
        bus.rd_way_i   = 4'b0100;
        #2;
        chk("rd1_rsp_valid", DW'(bus.rsp_valid_o), DW'(1));
        chk("rd1_data", bus.rsp_data_o, D_A5);
        chk("rd1_hit", DW'(bus.rsp_hit_o), DW'(1));
        chk("rd1_err", DW'(bus.rsp_err_o), DW'(0));
        tick();
        chk("rd1_done", DW'(bus.rsp_valid_o), DW'(0));

        // Four back-to-back reads from way1
        bus.rd_way_i = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.rd_valid_i = (k < 4);
            bus.rd_addr_i  = 10'h020 + 10'(k);
            #2;
            if (k < 4) chk("b2b_rd_ready", DW'(bus.rd_ready_o), DW'(1));
            if (k > 0) begin
                chk("b2b_rsp_valid", DW'(bus.rsp_valid_o), DW'(1));
                chk("b2b_data", bus.rsp_data_o, {16{8'h40 + 8'(k - 1)}});
            end
        end
        tick();
        chk("b2b_done", DW'(bus.rsp_valid_o), DW'(0));

        // Stall three cycles while a refill rewrites the same row
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = 10'h010;
        tick();
        bus.rd_valid_i  = 1'b0;
        bus.rd_way_i    = 4'b0100;
        bus.rsp_ready_i = 1'b0;
        #2;
        chk("stall_rsp0", bus.rsp_data_o, D_A5);
        for (int k = 0; k < 2; k++) begin
            tick();
            bus.fill_valid_i = 1'b1;
            bus.fill_addr_i  = 10'h010;
            bus.fill_way_i   = 4'b0100;
            bus.fill_data_i  = D_5A;
            if (k == 1) bus.rd_way_i = 4'b0000;
            #2;
            chk("stall_fill_req", DW'(bus.sram_req_o), DW'(4'b0100));
            chk("stall_valid", DW'(bus.rsp_valid_o), DW'(1));
            chk("stall_data", bus.rsp_data_o, D_A5);
            chk("stall_hit", DW'(bus.rsp_hit_o), DW'(1));
        end
        tick();
        bus.fill_valid_i = 1'b0;
        bus.rsp_ready_i  = 1'b1;
        #2;
        chk("hold_release_valid", DW'(bus.rsp_valid_o), DW'(1));
        chk("hold_release_data", bus.rsp_data_o, D_A5);
        tick();
        chk("hold_done", DW'(bus.rsp_valid_o), DW'(0));
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = 10'h010;
        tick();
        bus.rd_valid_i = 1'b0;
        bus.rd_way_i   = 4'b0100;
        #2;
        chk("refilled_data", bus.rsp_data_o, D_5A);

        // Fill and read collide
        tick();
        bus.fill_valid_i = 1'b1;
        bus.fill_addr_i  = 10'h030;
        bus.fill_way_i   = 4'b1000;
        bus.fill_data_i  = D_C3;
        bus.rd_valid_i   = 1'b1;
        bus.rd_addr_i    = 10'h030;
        #2;
        chk("coll_rd_ready", DW'(bus.rd_ready_o), DW'(0));
        chk("coll_req", DW'(bus.sram_req_o), DW'(4'b1000));
        chk("coll_we", DW'(bus.sram_we_o), DW'(1));
        tick();
        bus.fill_valid_i = 1'b0;
        #2;
        chk("coll_rd_ready2", DW'(bus.rd_ready_o), DW'(1));
        chk("coll_req2", DW'(bus.sram_req_o), DW'(4'b1111));
        tick();
        bus.rd_valid_i = 1'b0;
        bus.rd_way_i   = 4'b1000;
        #2;
        chk("coll_data", bus.rsp_data_o, D_C3);

        // Multi-hit and miss
        tick();
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = 10'h010;
        tick();
        bus.rd_way_i = 4'b0011;
        #2;
        chk("multi_err", DW'(bus.rsp_err_o), DW'(1));
        chk("multi_hit", DW'(bus.rsp_hit_o), DW'(1));
        chk("multi_data", bus.rsp_data_o, D_33);
        tick();
        bus.rd_valid_i = 1'b0;
        bus.rd_way_i   = 4'b0000;
        #2;
        chk("miss_valid", DW'(bus.rsp_valid_o), DW'(1));
        chk("miss_hit", DW'(bus.rsp_hit_o), DW'(0));
        chk("miss_err", DW'(bus.rsp_err_o), DW'(0));
        chk("miss_data", bus.rsp_data_o, DW'(0));

        // Flush while holding, refill still goes through
        tick();
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = 10'h010;
        tick();
        bus.rd_valid_i  = 1'b0;
        bus.rd_way_i    = 4'b0100;
        bus.rsp_ready_i = 1'b0;
        tick();
        bus.flush_i      = 1'b1;
        bus.fill_valid_i = 1'b1;
        bus.fill_addr_i  = 10'h040;
        bus.fill_way_i   = 4'b0001;
        bus.fill_data_i  = D_11;
        #2;
        chk("flush_valid", DW'(bus.rsp_valid_o), DW'(0));
        chk("flush_fill_req", DW'(bus.sram_req_o), DW'(4'b0001));
        tick();
        bus.flush_i      = 1'b0;
        bus.fill_valid_i = 1'b0;
        bus.rsp_ready_i  = 1'b1;
        #2;
        chk("flush_idle_valid", DW'(bus.rsp_valid_o), DW'(0));
        chk("flush_idle_ready", DW'(bus.rd_ready_o), DW'(1));

        // Reset while a response is pending
        tick();
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = 10'h010;
        tick();
        bus.rd_valid_i = 1'b0;
        rst            = 1'b1;
        #2;
        chk("rstrd_valid", DW'(bus.rsp_valid_o), DW'(0));
        tick();
        rst = 1'b0;
        #2;
        chk("rstrd_after_valid", DW'(bus.rsp_valid_o), DW'(0));
        chk("rstrd_after_ready", DW'(bus.rd_ready_o), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
